battle_turn_ctrl: RTL and testbench
===================================

# battle_turn_ctrl

Turn sequencer and hit-point keeper that sits directly upstream and downstream of the enemy bullet-pattern stage. It drives that stage's `state_in`/`turn_in`, consumes its `busy`/`finished`/`damage` pulses, tracks player and enemy HP, and decides win/lose. All outputs are registered; one 65 MHz pixel clock domain.

## Interface
- `PLAYER_HP`, 20: player HP loaded at game start (≤255).
- `ENEMY_HP`, 30: enemy HP loaded at game start (≤255).
- `HIT_DMG`, 4: player HP lost per accepted enemy hit.
- `ATTACK_DMG`, 5: enemy HP lost per player attack.
- `INVULN_CYCLES`, 32_500_000: post-hit invulnerability window (0.5 s).
- `ENEMY_TIMEOUT`, 650_000_000: max cycles in ENEMY phase (10 s).
- `NUM_PATTERNS`, 4: `turn_out` wraps modulo this.

- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  one-cycle debounced pulse.
- `attack_btn`  in  1  one-cycle debounced pulse.
- `enemy_busy`  in  1  enemy stage busy level.
- `enemy_finished`  in  1  enemy stage one-cycle done pulse.
- `enemy_damage`  in  1  enemy stage one-cycle hit pulse.
- `state_out`  out  4  game state; drives enemy `state_in`.
- `turn_out`  out  4  pattern index; drives enemy `turn_in`.
- `player_hp`  out  8  current player HP.
- `enemy_hp`  out  8  current enemy HP.
- `invuln_out`  out  1  high during invulnerability window (HUD blink).
- `hit_flash`  out  1  one-cycle pulse per accepted hit.

## Operation
- States (4-bit codes, fixed): TITLE 4'b0000, PLAYER 4'b0100, ENEMY 4'b1000, GAME_OVER 4'b1111, VICTORY 4'b1110. The enemy stage starts only on a change into 4'b1000, so ENEMY is never re-entered without at least one cycle in another state.
- TITLE: `start_btn` → load `player_hp`=PLAYER_HP, `enemy_hp`=ENEMY_HP, `turn_out`=0, clear invuln → PLAYER.
- PLAYER: `attack_btn` → `enemy_hp` -= ATTACK_DMG, saturating at 0. If the result is 0 → VICTORY, else → ENEMY. Other inputs are ignored.
- ENEMY:
  - `enemy_damage` with invuln clear → `player_hp` -= HIT_DMG (saturating at 0), `hit_flash`=1, start invuln timer.
  - `enemy_damage` with invuln set → ignored.
  - `player_hp` reaching 0 → GAME_OVER on the next cycle, regardless of `enemy_busy`.
  - `enemy_finished`, or timeout counter = ENEMY_TIMEOUT-1 → PLAYER, with `turn_out` ← (`turn_out`+1) mod NUM_PATTERNS.
- Same-cycle `enemy_damage` and `enemy_finished`: damage is applied first. HP 0 → GAME_OVER (turn not incremented), else → PLAYER with turn incremented.
- GAME_OVER / VICTORY: `start_btn` → TITLE. HP values hold until then.
- Invuln timer counts down across state changes, but is cleared on entry to TITLE.

## Timing
- Reset values: `state_out`=TITLE, `turn_out`=0, `player_hp`=PLAYER_HP, `enemy_hp`=ENEMY_HP, `invuln_out`=0, `hit_flash`=0. All internal counters are 0.
- Input pulse → registered output change: 1 cycle (state, HP, `hit_flash`).
- `invuln_out` rises in the same cycle as `hit_flash` and stays high exactly INVULN_CYCLES cycles.
- Timeout counter resets on every entry to ENEMY. Timeout fires after exactly ENEMY_TIMEOUT cycles in ENEMY.
- Reset asserted mid-phase returns all outputs to reset values immediately (asynchronous assert). Deassert is synchronised with a 2-flop release.
- HP arithmetic is 8-bit unsigned, saturating subtraction, no wrap. `turn_out` wraps NUM_PATTERNS-1 → 0.

## Structure
- Package `battle_pkg`: state code localparams (TITLE, PLAYER, ENEMY, GAME_OVER, VICTORY) and the 8-bit `hp_t` typedef. These are shared with the enemy stage and the HUD renderer.
- One sub-module, `cycle_timer`: a loadable down-counter with `load`, `count`, `active`, and `expire` pulse. It is instantiated twice: invulnerability and enemy timeout.

## Test plan
- Reset, then `start_btn` → `state_out` 0000→0100 one cycle later, HP 20/30, turn 0.
- PLAYER `attack_btn` → `enemy_hp`=25, `state_out`=1000; `enemy_finished` pulse → `state_out`=0100, `turn_out`=1. Repeat 4 turns → `turn_out` wraps to 0.
- ENEMY, two `enemy_damage` pulses 10 cycles apart (INVULN_CYCLES=100 for sim) → `player_hp`=16 only, one `hit_flash`, `invuln_out` high exactly 100 cycles.
- `player_hp`=4, `enemy_damage` and `enemy_finished` in the same cycle → `player_hp`=0, `state_out`=1111, `turn_out` unchanged.
- Six attacks with enemy phases between (`enemy_hp` 30→0) → VICTORY 1110; `start_btn` → TITLE; next `start_btn` → HP reloaded.
- ENEMY with no `enemy_finished` (ENEMY_TIMEOUT=1000 for sim) → PLAYER after exactly 1000 cycles. Assert `rst` low mid-ENEMY → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/battle_pkg.sv
// battle_pkg: game state codes and HP type shared by
// the turn controller, the enemy pattern stage and the HUD.
package battle_pkg;

  localparam logic [3:0] TITLE     = 4'b0000;
  localparam logic [3:0] PLAYER    = 4'b0100;
  localparam logic [3:0] ENEMY     = 4'b1000;
  localparam logic [3:0] GAME_OVER = 4'b1111;
  localparam logic [3:0] VICTORY   = 4'b1110;

  typedef logic [7:0] hp_t;

  typedef enum logic [3:0] {
    ST_TITLE     = TITLE,
    ST_PLAYER    = PLAYER,
    ST_ENEMY     = ENEMY,
    ST_GAME_OVER = GAME_OVER,
    ST_VICTORY   = VICTORY
  } state_e;

  function automatic hp_t hp_sub(hp_t a, hp_t b);
    return (a > b) ? hp_t'(a - b) : '0;
  endfunction

endpackage

// File: rtl/battle_turn_ctrl_cycle_timer.sv
// cycle_timer: loadable down-counter, active while
// nonzero, expire pulses on the last counted cycle.
module cycle_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         count_i,
  input  logic         clear_i,
  input  logic [W-1:0] value_i,
  output logic         active_o,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear beats load beats decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = value_i;
    else if (count_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign active_o = (cnt_q != '0);
  assign expire_o = count_i && (cnt_q == W'(1));

endmodule

// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: turn sequencer and HP keeper around
// the enemy bullet-pattern stage.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int unsigned PLAYER_HP     = 20,
  parameter int unsigned ENEMY_HP      = 30,
  parameter int unsigned HIT_DMG       = 4,
  parameter int unsigned ATTACK_DMG    = 5,
  parameter int unsigned INVULN_CYCLES = 32_500_000,
  parameter int unsigned ENEMY_TIMEOUT = 650_000_000,
  parameter int unsigned NUM_PATTERNS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       attack_btn,
  input  logic       enemy_busy,
  input  logic       enemy_finished,
  input  logic       enemy_damage,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic [7:0] player_hp,
  output logic [7:0] enemy_hp,
  output logic       invuln_out,
  output logic       hit_flash
);

  localparam hp_t        P_HP  = hp_t'(PLAYER_HP);
  localparam hp_t        E_HP  = hp_t'(ENEMY_HP);
  localparam hp_t        HIT_D = hp_t'(HIT_DMG);
  localparam hp_t        ATK_D = hp_t'(ATTACK_DMG);
  localparam logic [3:0] T_MAX = 4'(NUM_PATTERNS - 1);
  localparam logic [31:0] INV_V = 32'(INVULN_CYCLES);
  localparam logic [31:0] TO_V  = 32'(ENEMY_TIMEOUT);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  state_e     state_q;
  logic [3:0] turn_q;
  hp_t        php_q;
  hp_t        ehp_q;
  logic       inv_q;
  logic       flash_q;

  logic       hit;
  hp_t        php_hit;
  hp_t        php_nx;
  hp_t        ehp_atk;
  logic [3:0] turn_inc;
  logic       enter_enemy;
  logic       inv_clr;
  logic       inv_act;
  logic       inv_exp;
  logic       to_exp;
  logic       to_act_unused;
  logic       busy_unused;

  assign busy_unused = enemy_busy;

  // async assert, two-flop synchronous release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rst_sync_q <= 2'b00;
    else
      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // per-cycle decisions feeding the FSM and both timers
  always_comb begin
    hit = (state_q == ST_ENEMY) && enemy_damage && !inv_q;
    php_hit = hp_sub(php_q, HIT_D);
    php_nx = hit ? php_hit : php_q;
    ehp_atk = hp_sub(ehp_q, ATK_D);
    turn_inc = (turn_q == T_MAX) ? 4'd0 : turn_q + 4'd1;
    enter_enemy = (state_q == ST_PLAYER) && attack_btn &&
                  (ehp_atk != '0);
    inv_clr = start_btn && ((state_q == ST_TITLE) ||
                            (state_q == ST_GAME_OVER) ||
                            (state_q == ST_VICTORY));
  end

  cycle_timer #(.W(32)) u_inv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (hit),
    .count_i  (1'b1),
    .clear_i  (inv_clr),
    .value_i  (INV_V),
    .active_o (inv_act),
    .expire_o (inv_exp)
  );

  cycle_timer #(.W(32)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (enter_enemy),
    .count_i  (state_q == ST_ENEMY),
    .clear_i  (1'b0),
    .value_i  (TO_V),
    .active_o (to_act_unused),
    .expire_o (to_exp)
  );

  // game FSM with registered HP, turn and HUD outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_TITLE;
      turn_q  <= '0;
      php_q   <= P_HP;
      ehp_q   <= E_HP;
      inv_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      flash_q <= hit;
      if (inv_clr)
        inv_q <= 1'b0;
      else
        inv_q <= hit || (inv_act && !inv_exp);
      unique case (state_q)
        ST_TITLE: begin
          if (start_btn) begin
            php_q   <= P_HP;
            ehp_q   <= E_HP;
            turn_q  <= '0;
            state_q <= ST_PLAYER;
          end
        end
        ST_PLAYER: begin
          if (attack_btn) begin
            ehp_q   <= ehp_atk;
            state_q <= (ehp_atk == '0) ? ST_VICTORY : ST_ENEMY;
          end
        end
        ST_ENEMY: begin
          php_q <= php_nx;
          if (php_nx == '0) begin
            state_q <= ST_GAME_OVER;
          end else if (enemy_finished || to_exp) begin
            state_q <= ST_PLAYER;
            turn_q  <= turn_inc;
          end
        end
        ST_GAME_OVER, ST_VICTORY: begin
          if (start_btn)
            state_q <= ST_TITLE;
        end
        default: state_q <= ST_TITLE;
      endcase
    end
  end

  assign state_out  = state_q;
  assign turn_out   = turn_q;
  assign player_hp  = php_q;
  assign enemy_hp   = ehp_q;
  assign invuln_out = inv_q;
  assign hit_flash  = flash_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// tb_battle_turn_ctrl: directed game sequence with an
// expected-snapshot queue checked after each DUT step.
module tb_battle_turn_ctrl;

  localparam logic [3:0] S_T = 4'b0000;
  localparam logic [3:0] S_P = 4'b0100;
  localparam logic [3:0] S_E = 4'b1000;
  localparam logic [3:0] S_G = 4'b1111;
  localparam logic [3:0] S_V = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       attack_btn;
  logic       enemy_busy;
  logic       enemy_finished;
  logic       enemy_damage;
  logic [3:0] state_out;
  logic [3:0] turn_out;
  logic [7:0] player_hp;
  logic [7:0] enemy_hp;
  logic       invuln_out;
  logic       hit_flash;

  always #5 clk = ~clk;

  battle_turn_ctrl #(
    .PLAYER_HP     (20),
    .ENEMY_HP      (30),
    .HIT_DMG       (4),
    .ATTACK_DMG    (5),
    .INVULN_CYCLES (100),
    .ENEMY_TIMEOUT (1000),
    .NUM_PATTERNS  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_btn      (start_btn),
    .attack_btn     (attack_btn),
    .enemy_busy     (enemy_busy),
    .enemy_finished (enemy_finished),
    .enemy_damage   (enemy_damage),
    .state_out      (state_out),
    .turn_out       (turn_out),
    .player_hp      (player_hp),
    .enemy_hp       (enemy_hp),
    .invuln_out     (invuln_out),
    .hit_flash      (hit_flash)
  );

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [3:0] tn;
    logic [7:0] ph;
    logic [7:0] eh;
    logic       inv;
    logic       fl;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_st;
  logic [3:0] m_tn;
  logic [7:0] m_ph;
  logic [7:0] m_eh;
  logic       m_inv;
  logic       m_fl;

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_now(input string tag);
    exp_t e;
    e.tag = tag;
    e.st  = m_st;
    e.tn  = m_tn;
    e.ph  = m_ph;
    e.eh  = m_eh;
    e.inv = m_inv;
    e.fl  = m_fl;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, " state"}, 32'(state_out), 32'(e.st));
    chk({e.tag, " turn"}, 32'(turn_out), 32'(e.tn));
    chk({e.tag, " php"}, 32'(player_hp), 32'(e.ph));
    chk({e.tag, " ehp"}, 32'(enemy_hp), 32'(e.eh));
    chk({e.tag, " invuln"}, 32'(invuln_out), 32'(e.inv));
    chk({e.tag, " flash"}, 32'(hit_flash), 32'(e.fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = S_T; m_tn = 4'd0; m_ph = 8'd20; m_eh = 8'd30;
    m_inv = 1'b0; m_fl = 1'b0;
  endtask

  task automatic next_turn();
    m_tn = (m_tn == 4'd3) ? 4'd0 : m_tn + 4'd1;
  endtask

  task automatic do_start(input string tag);
    expect_now(tag);
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    compare();
  endtask

  task automatic do_attack(input string tag);
    expect_now(tag);
    attack_btn = 1'b1; tick(); attack_btn = 1'b0;
    compare();
  endtask

  task automatic do_finish(input string tag);
    expect_now(tag);
    enemy_finished = 1'b1; tick(); enemy_finished = 1'b0;
    compare();
  endtask

  task automatic do_hit(input string tag);
    expect_now(tag);
    enemy_damage = 1'b1; tick(); enemy_damage = 1'b0;
    compare();
  endtask

  initial begin
    int n;
    int fl;
    rst = 1'b0;
    start_btn = 1'b0;
    attack_btn = 1'b0;
    enemy_busy = 1'b0;
    enemy_finished = 1'b0;
    enemy_damage = 1'b0;
    model_reset();
    repeat (3) tick();
    expect_now("reset");
    compare();
    rst = 1'b1;
    repeat (4) tick();

    m_st = S_P;
    do_start("start");

    for (int i = 0; i < 4; i++) begin
      m_eh = m_eh - 8'd5; m_st = S_E;
      do_attack("attack");
      m_st = S_P; next_turn();
      do_finish("finish");
    end

    m_eh = m_eh - 8'd5; m_st = S_E;
    do_attack("attack5");
    m_ph = 8'd16; m_fl = 1'b1; m_inv = 1'b1;
    enemy_busy = 1'b1;
    do_hit("hit1");
    n = 0;
    fl = 0;
    while (invuln_out === 1'b1 && n < 1000) begin
      if (hit_flash === 1'b1) fl++;
      n++;
      enemy_damage = (n == 10);
      tick();
    end
    enemy_damage = 1'b0;
    enemy_busy = 1'b0;
    chk("invuln_len", 32'(n), 32'd100);
    chk("flash_count", 32'(fl), 32'd1);
    m_fl = 1'b0; m_inv = 1'b0;
    expect_now("after_invuln");
    compare();
    m_st = S_P; next_turn();
    do_finish("finish5");

    m_eh = 8'd0; m_st = S_V;
    do_attack("victory");
    m_st = S_T;
    do_start("to_title");
    m_st = S_P; m_ph = 8'd20; m_eh = 8'd30; m_tn = 4'd0;
    do_start("reload");

    m_eh = 8'd25; m_st = S_E;
    do_attack("to_attack");
    m_st = S_P; next_turn();
    expect_now("timeout");
    n = 0;
    while (state_out === S_E && n < 2000) begin
      n++;
      tick();
    end
    chk("timeout_len", 32'(n), 32'd1000);
    compare();

    m_eh = 8'd20; m_st = S_E;
    do_attack("go_attack");
    enemy_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_ph = m_ph - 8'd4; m_fl = 1'b1; m_inv = 1'b1;
      do_hit("hit_n");
      repeat (104) tick();
    end
    m_ph = 8'd0; m_st = S_G;
    expect_now("dmg_fin");
    enemy_damage = 1'b1; enemy_finished = 1'b1;
    tick();
    enemy_damage = 1'b0; enemy_finished = 1'b0;
    compare();
    enemy_busy = 1'b0;

    m_st = S_T; m_fl = 1'b0; m_inv = 1'b0;
    do_start("go_title");
    m_st = S_P; m_ph = 8'd20; m_eh = 8'd30; m_tn = 4'd0;
    do_start("restart");
    m_eh = 8'd25; m_st = S_E;
    do_attack("rst_attack");
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    expect_now("mid_reset");
    compare();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
